// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs DMA master.
// CPU has priority; a starvation counter forces periodic DMA grants.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_dma;

    assign force_dma = dma_req & (starve_cnt == LIMIT);
    assign dma_gnt   = dma_req & (force_dma | ~cpu_req);
    assign cpu_gnt   = cpu_req & ~dma_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Route the granted master onto the memory port; CPU side when idle.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_gnt & ~cpu_wr;
        mem_wr    = cpu_gnt & cpu_wr;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_rd    = ~dma_wr;
            mem_wr    = dma_wr;
        end
    end

    // Count consecutive denied DMA cycles, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dma_req & ~dma_gnt) begin
            if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Capture read data one cycle after a read grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_wr;
            dma_rvalid <= dma_gnt & ~dma_wr;
            if (cpu_gnt & ~cpu_wr)
                cpu_rdata <= mem_rdata;
            if (dma_gnt & ~dma_wr)
                dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a
// transaction-level reference model and a behavioural memory.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_wr = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic        dma_req = 0, dma_wr = 0;
    logic [31:0] dma_addr = 0, dma_wdata = 0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    int passed = 0;
    int total  = 0;

    // memory environment
    logic [31:0] env_mem [256];
    // reference model state
    logic [31:0] ref_mem [256];
    int          m_wait;
    logic        m_crv, m_drv, m_cg, m_dg;
    logic [31:0] m_crd, m_drd;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = env_mem[mem_addr[9:2]];

    always @(posedge clk)
        if (mem_wr && !reset)
            env_mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_crv = 0; m_drv = 0;
        m_crd = 0; m_drd = 0;
    endtask

    // Compare all outputs against the model, then advance the model
    // to what the coming clock edge must produce.
    task automatic model_check();
        logic [31:0] ea, ewd;
        logic        erd, ewr;
        m_dg = dma_req && (!cpu_req || m_wait >= LIM);
        m_cg = cpu_req && !m_dg;
        ea  = m_dg ? dma_addr : cpu_addr;
        ewd = m_dg ? dma_wdata : cpu_wdata;
        erd = (m_cg && !cpu_wr) || (m_dg && !dma_wr);
        ewr = (m_cg && cpu_wr) || (m_dg && dma_wr);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cg));
        chk("dma_gnt", 32'(dma_gnt), 32'(m_dg));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !m_cg));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_rd", 32'(mem_rd), 32'(erd));
        chk("mem_wr", 32'(mem_wr), 32'(ewr));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
        chk("dma_rdata", dma_rdata, m_drd);
        m_crv = m_cg && !cpu_wr;
        m_drv = m_dg && !dma_wr;
        if (m_crv) m_crd = ref_mem[ea[9:2]];
        if (m_drv) m_drd = ref_mem[ea[9:2]];
        if (ewr) ref_mem[ea[9:2]] = ewd;
        if (dma_req && !m_dg)
            m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        else
            m_wait = 0;
    endtask

    task automatic cyc(input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
        model_check();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    string pat;
    logic  c_p, c_w, d_p, d_w;
    logic [31:0] c_a, c_d, d_a, d_d;

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'(i * 12);
            ref_mem[i] = 32'(i * 12);
        end
        model_reset();
        #2;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        #2 reset = 0;

        // CPU only: write then read back
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("cw_gnt", 32'(cpu_gnt), 32'h1);
        chk("cw_memwr", 32'(mem_wr), 32'h1);
        cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk("cr_gnt", 32'(cpu_gnt), 32'h1);
        chk("cr_memrd", 32'(mem_rd), 32'h1);
        idle();
        chk("cr_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("cr_rdata", cpu_rdata, 32'hDEADBEEF);

        // DMA only: read word 1 (holds 12)
        cyc(0, 0, 0, 0, 1, 0, 32'h4, 0);
        chk("dr_gnt", 32'(dma_gnt), 32'h1);
        idle();
        chk("dr_rvalid", 32'(dma_rvalid), 32'h1);
        chk("dr_rdata", dma_rdata, 32'd12);
        chk("dr_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

        // Constant contention
        pat = "CCCCDCCCCDCC";
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
            chk($sformatf("cont%0d_dg", i), 32'(dma_gnt),
                32'(pat[i] == "D"));
            chk($sformatf("cont%0d_stall", i), 32'(cpu_stall),
                32'(pat[i] == "D"));
        end
        idle();

        // Counter restarts after DMA drops its request
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
        cyc(1, 0, 32'h40, 0, 0, 0, 32'h80, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 32'h40, 0, 1, 0, 32'h80, 0);
            chk($sformatf("restart%0d_dg", i), 32'(dma_gnt),
                32'(i == 4));
        end
        idle();

        // Same-address write collision
        cyc(1, 1, 32'h20, 32'h1, 1, 1, 32'h20, 32'h2);
        chk("col_cg", 32'(cpu_gnt), 32'h1);
        chk("col_dg", 32'(dma_gnt), 32'h0);
        cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h2);
        chk("col_dg2", 32'(dma_gnt), 32'h1);
        cyc(1, 0, 32'h20, 0, 0, 0, 0, 0);
        idle();
        chk("col_final", cpu_rdata, 32'h2);

        // Async reset with rvalid pending and counter nonzero
        cyc(1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
        @(posedge clk);
        #1;
        cpu_req = 0; dma_req = 0;
        chk("pre_rst_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("pre_rst_cnt", 32'(dut.starve_cnt), 32'h1);
        #2 reset = 1;
        #1;
        chk("arst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("arst_cpu_rdata", cpu_rdata, 32'h0);
        chk("arst_dma_rdata", dma_rdata, 32'h0);
        chk("arst_cnt", 32'(dut.starve_cnt), 32'h0);
        @(posedge clk);
        #2 reset = 0;
        model_reset();

        // Randomized traffic obeying the hold-until-grant protocol
        c_p = 0; d_p = 0;
        c_w = 0; d_w = 0;
        c_a = 0; d_a = 0; c_d = 0; d_d = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!c_p && $urandom_range(0, 9) < 7) begin
                c_p = 1;
                c_w = 1'($urandom_range(0, 1));
                c_a = 32'($urandom_range(0, 15)) << 2;
                c_d = $urandom;
            end
            if (!d_p && $urandom_range(0, 9) < 5) begin
                d_p = 1;
                d_w = 1'($urandom_range(0, 1));
                d_a = 32'($urandom_range(0, 15)) << 2;
                d_d = $urandom;
            end
            cyc(c_p, c_w, c_a, c_d, d_p, d_w, d_a, d_d);
            if (m_cg) c_p = 0;
            if (m_dg) d_p = 0;
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
